// File: rtl/ysyx_25060170_ifu_fq.sv
// ysyx_25060170_ifu_fq: fetch unit with PC register, single-outstanding imem port and DEPTH-entry fetch queue
// Ports: clk/rst (async active-high); id/ie/ls_pc_jump+target redirects (LS > EX > ID);
// imem_req_valid/ready/addr request port; imem_resp_valid/inst in-order responses;
// if_valid/id_ready/pc_o/inst_o queue head to ID; fq_count occupied entries.
module ysyx_25060170_ifu_fq #(
  parameter int XLEN = 32,
  parameter int ILEN = 32,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int PC_STEP = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_pc_jump,
  input  logic [XLEN-1:0]            id_pc_i,
  input  logic                       ie_pc_jump,
  input  logic [XLEN-1:0]            ie_pc_i,
  input  logic                       ls_pc_jump,
  input  logic [XLEN-1:0]            ls_pc_i,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_resp_valid,
  input  logic [ILEN-1:0]            imem_resp_inst,
  output logic                       if_valid,
  input  logic                       id_ready,
  output logic [XLEN-1:0]            pc_o,
  output logic [ILEN-1:0]            inst_o,
  output logic [$clog2(DEPTH):0]     fq_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [XLEN-1:0] fetch_pc, fetch_pc_n, out_pc, target;
  logic epoch, outstanding, outstanding_n, out_epoch, req_epoch;
  logic redirect, hs, push, pop;
  logic [AW-1:0] head, tail;
  logic [CW-1:0] count, count_n;
  logic [XLEN-1:0] pc_q [DEPTH];
  logic [ILEN-1:0] inst_q [DEPTH];
  always_comb begin
    redirect = ls_pc_jump | ie_pc_jump | id_pc_jump;
    target = ls_pc_jump ? ls_pc_i : ie_pc_jump ? ie_pc_i : id_pc_i;
    hs = imem_req_valid & imem_req_ready;
    push = imem_resp_valid & outstanding & (out_epoch == epoch) & ~redirect;
    pop = if_valid & id_ready;
    outstanding_n = hs | (outstanding & ~imem_resp_valid);
    count_n = redirect ? '0 : count + CW'(push) - CW'(pop);
    // a request issued before a redirect must not advance the redirected PC
    fetch_pc_n = redirect ? target : (hs & (req_epoch == epoch)) ? fetch_pc + XLEN'(PC_STEP) : fetch_pc;
  end
  assign if_valid = (count != '0) & ~redirect;
  assign pc_o = pc_q[head];
  assign inst_o = inst_q[head];
  assign fq_count = count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      epoch <= 1'b0;
      outstanding <= 1'b0;
      out_epoch <= 1'b0;
      out_pc <= '0;
      req_epoch <= 1'b0;
      imem_req_valid <= 1'b0;
      imem_req_addr <= '0;
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i] <= '0;
        inst_q[i] <= '0;
      end
    end else begin
      fetch_pc <= fetch_pc_n;
      epoch <= epoch ^ redirect;
      outstanding <= outstanding_n;
      count <= count_n;
      if (hs) begin
        out_pc <= imem_req_addr;
        out_epoch <= req_epoch;
      end
      // a stalled request stays frozen; otherwise issue when free, credited and not redirecting
      if (!(imem_req_valid && !imem_req_ready)) begin
        imem_req_valid <= ~outstanding_n & (count_n < CW'(DEPTH)) & ~redirect;
        imem_req_addr <= fetch_pc;
        req_epoch <= epoch;
      end
      if (redirect) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) begin
          pc_q[tail] <= out_pc;
          inst_q[tail] <= imem_resp_inst;
          tail <= tail + AW'(1);
        end
        if (pop) head <= head + AW'(1);
      end
    end
  end
  assert property (@(posedge clk) disable iff (rst) !push || count < CW'(DEPTH));
endmodule
